// File: rtl/hall_decoder_pkg.sv
// hall_decoder_pkg: shared motor-side definitions.
// Holds the Hall-code-to-step table, the invalid-code constants, the ring
// adjacency tables (also used by the pattern generator) and the decoder FSM
// state enumeration.
package hall_decoder_pkg;

  // Hall codes that never occur on a healthy 120-degree sensor set
  localparam logic [2:0] HALL_INVALID_LO = 3'b000;
  localparam logic [2:0] HALL_INVALID_HI = 3'b111;

  // Step reported before any valid code has been seen
  localparam logic [2:0] STEP_RESET = 3'd5;

  // Decoder tracking states
  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_TRACK = 2'd1,
    ST_STALL = 2'd2
  } hall_state_e;

  // True for the two codes that cannot be mapped to a step
  function automatic logic hall_is_invalid(input logic [2:0] code);
    return (code == HALL_INVALID_LO) || (code == HALL_INVALID_HI);
  endfunction

  // Hall code {C,B,A} to commutation step 0..5
  function automatic logic [2:0] hall_to_step(input logic [2:0] code);
    logic [2:0] step;
    case (code)
      3'b101:  step = 3'd0;
      3'b100:  step = 3'd1;
      3'b110:  step = 3'd2;
      3'b010:  step = 3'd3;
      3'b011:  step = 3'd4;
      3'b001:  step = 3'd5;
      default: step = STEP_RESET;
    endcase
    return step;
  endfunction

  // Next step on the ring 0->1->2->3->4->5->0
  function automatic logic [2:0] step_inc(input logic [2:0] step);
    logic [2:0] nxt;
    case (step)
      3'd0:    nxt = 3'd1;
      3'd1:    nxt = 3'd2;
      3'd2:    nxt = 3'd3;
      3'd3:    nxt = 3'd4;
      3'd4:    nxt = 3'd5;
      3'd5:    nxt = 3'd0;
      default: nxt = 3'd0;
    endcase
    return nxt;
  endfunction

  // Previous step on the ring
  function automatic logic [2:0] step_dec(input logic [2:0] step);
    logic [2:0] prv;
    case (step)
      3'd0:    prv = 3'd5;
      3'd1:    prv = 3'd0;
      3'd2:    prv = 3'd1;
      3'd3:    prv = 3'd2;
      3'd4:    prv = 3'd3;
      3'd5:    prv = 3'd4;
      default: prv = 3'd0;
    endcase
    return prv;
  endfunction

endpackage

// File: rtl/hall_decoder_debounce.sv
// hall_debounce: two-flop synchroniser for the asynchronous Hall lines
// followed by a stability filter. A code is offered once, as a one-cycle
// o_accept strobe, after it has been stable for K_DEBOUNCE synchronised
// cycles and only if it differs from the previously accepted code.
// The "last accepted" register resets to 000 so that idle/unpowered sensor
// lines right after reset do not raise a spurious invalid event.
module hall_debounce #(
  parameter int K_DEBOUNCE = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [2:0] i_hall,
  output logic [2:0] o_code,
  output logic       o_accept
);

  localparam int CW = (K_DEBOUNCE > 1) ? $clog2(K_DEBOUNCE) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(K_DEBOUNCE - 1);

  logic [2:0]    r_sync1;
  logic [2:0]    r_sync2;
  logic [2:0]    r_cand;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_last;
  logic          w_accept;

  // Two-stage synchroniser for the raw sensor lines
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 3'b000;
      r_sync2 <= 3'b000;
    end else begin
      r_sync1 <= i_hall;
      r_sync2 <= r_sync1;
    end
  end

  // Stability counter: restart on any code change, saturate while held
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cand <= 3'b000;
      r_cnt  <= '0;
    end else if (r_sync2 != r_cand) begin
      r_cand <= r_sync2;
      r_cnt  <= '0;
    end else if (r_cnt != CNT_MAX) begin
      r_cand <= r_cand;
      r_cnt  <= r_cnt + CW'(1);
    end else begin
      r_cand <= r_cand;
      r_cnt  <= r_cnt;
    end
  end

  assign w_accept = (r_cnt == CNT_MAX) && (r_cand != r_last);

  // Remember the accepted code so each code is reported only once
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last <= 3'b000;
    end else if (w_accept) begin
      r_last <= r_cand;
    end else begin
      r_last <= r_last;
    end
  end

  assign o_code   = r_cand;
  assign o_accept = w_accept;

endmodule

// File: rtl/hall_decoder.sv
// hall_decoder: decodes debounced Hall codes into the 0..5 commutation step
// and reports direction, inter-commutation period, stall, invalid-code and
// skipped-step events. All outputs are registered.
// Optional feature macro: HALL_DECODER_PERIOD_EN builds the period counter,
// o_period, o_stalled and the ST_STALL state; without it o_period and
// o_stalled read constant zero.
module hall_decoder
  import hall_decoder_pkg::*;
#(
  parameter int K_DEBOUNCE = 4,
  parameter int K_PERIOD_W = 20
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [2:0]            i_hall,
  input  logic                  i_step_polarity_rev,
  output logic [2:0]            o_step,
  output logic                  o_step_valid,
  output logic                  o_step_change,
  output logic                  o_direction,
  output logic [K_PERIOD_W-1:0] o_period,
  output logic                  o_stalled,
  output logic                  o_invalid,
  output logic                  o_skip
);

  localparam logic [K_PERIOD_W-1:0] PERIOD_ALL_ONES = {K_PERIOD_W{1'b1}};

  logic [2:0]            w_code;
  logic                  w_accept;
  logic                  w_acc_valid;
  logic                  w_acc_invalid;
  logic [2:0]            w_new_step;
  logic [K_PERIOD_W-1:0] w_cnt;
  logic                  w_cnt_sat;

  hall_decoder_pkg::hall_state_e r_state;
  hall_decoder_pkg::hall_state_e w_state_nxt;

  logic [2:0]            r_step;
  logic                  r_step_valid;
  logic                  r_step_change;
  logic                  r_direction;
  logic [K_PERIOD_W-1:0] r_period;
  logic                  r_stalled;
  logic                  r_invalid;
  logic                  r_skip;

  logic [2:0]            w_step_nxt;
  logic                  w_valid_nxt;
  logic                  w_change_nxt;
  logic                  w_dir_nxt;
  logic [K_PERIOD_W-1:0] w_period_nxt;
  logic                  w_stalled_nxt;
  logic                  w_invalid_nxt;
  logic                  w_skip_nxt;

  hall_debounce #(
    .K_DEBOUNCE (K_DEBOUNCE)
  ) u_debounce (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_hall   (i_hall),
    .o_code   (w_code),
    .o_accept (w_accept)
  );

  assign w_acc_invalid = w_accept && hall_is_invalid(w_code);
  assign w_acc_valid   = w_accept && !hall_is_invalid(w_code);
  assign w_new_step    = hall_to_step(w_code);

`ifdef HALL_DECODER_PERIOD_EN
  logic [K_PERIOD_W-1:0] r_cnt;

  // Free-running period counter, restarted at 1 by each valid acceptance
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (w_acc_valid) begin
      r_cnt <= K_PERIOD_W'(1);
    end else if (r_cnt != PERIOD_ALL_ONES) begin
      r_cnt <= r_cnt + K_PERIOD_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign w_cnt     = r_cnt;
  assign w_cnt_sat = (r_cnt == PERIOD_ALL_ONES);
`else
  assign w_cnt     = '0;
  assign w_cnt_sat = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state; invalid codes never move the state, acceptance beats stall
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT: begin
        if (w_acc_valid) w_state_nxt = ST_TRACK;
        else             w_state_nxt = ST_INIT;
      end
      ST_TRACK: begin
        if (w_acc_valid)    w_state_nxt = ST_TRACK;
        else if (w_cnt_sat) w_state_nxt = ST_STALL;
        else                w_state_nxt = ST_TRACK;
      end
      ST_STALL: begin
        if (w_acc_valid) w_state_nxt = ST_TRACK;
        else             w_state_nxt = ST_STALL;
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  // FSM outputs: next values for the registered output set
  always_comb begin
    w_step_nxt    = r_step;
    w_valid_nxt   = r_step_valid;
    w_change_nxt  = 1'b0;
    w_dir_nxt     = r_direction;
    w_period_nxt  = r_period;
    w_stalled_nxt = r_stalled;
    w_invalid_nxt = w_acc_invalid;
    w_skip_nxt    = 1'b0;
    case (r_state)
      ST_INIT: begin
        // First valid code: no history, so direction and period are left alone
        if (w_acc_valid) begin
          w_step_nxt   = w_new_step;
          w_valid_nxt  = 1'b1;
          w_change_nxt = 1'b1;
        end else begin
          w_change_nxt = 1'b0;
        end
      end
      ST_TRACK, ST_STALL: begin
        if (w_acc_valid) begin
          w_step_nxt    = w_new_step;
          w_change_nxt  = 1'b1;
          w_stalled_nxt = 1'b0;
          if (w_new_step == step_inc(r_step)) begin
            w_dir_nxt = i_step_polarity_rev;
          end else if (w_new_step == step_dec(r_step)) begin
            w_dir_nxt = ~i_step_polarity_rev;
          end else begin
            w_skip_nxt = 1'b1;
          end
          // Leaving stall: the elapsed time overflowed, keep the period invalid
          if (r_state == ST_STALL) w_period_nxt = PERIOD_ALL_ONES;
          else                     w_period_nxt = w_cnt;
        end else if ((r_state == ST_TRACK) && w_cnt_sat) begin
          w_stalled_nxt = 1'b1;
          w_period_nxt  = PERIOD_ALL_ONES;
        end else begin
          w_stalled_nxt = r_stalled;
        end
      end
      default: begin
        w_step_nxt = r_step;
      end
    endcase
  end

  // Output registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_step        <= STEP_RESET;
      r_step_valid  <= 1'b0;
      r_step_change <= 1'b0;
      r_direction   <= 1'b0;
      r_period      <= '0;
      r_stalled     <= 1'b0;
      r_invalid     <= 1'b0;
      r_skip        <= 1'b0;
    end else begin
      r_step        <= w_step_nxt;
      r_step_valid  <= w_valid_nxt;
      r_step_change <= w_change_nxt;
      r_direction   <= w_dir_nxt;
      r_period      <= w_period_nxt;
      r_stalled     <= w_stalled_nxt;
      r_invalid     <= w_invalid_nxt;
      r_skip        <= w_skip_nxt;
    end
  end

  assign o_step        = r_step;
  assign o_step_valid  = r_step_valid;
  assign o_step_change = r_step_change;
  assign o_direction   = r_direction;
  assign o_period      = r_period;
  assign o_stalled     = r_stalled;
  assign o_invalid     = r_invalid;
  assign o_skip        = r_skip;

endmodule
